// File: rtl/requant_pack.sv
// Requantization stage: bias, fixed-point multiply, rounding shift, offset and clamp,
// followed by packing of int8 results four per word. Four-stage stallable pipeline.
module requant_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_acc,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_bytes,
    output logic        busy
);

    // Divide by 2^e rounding to nearest, ties away from zero.
    function automatic logic [31:0] round_div_pot(input logic [31:0] h, input logic [4:0] e);
        logic [31:0]        mask;
        logic [31:0]        rem;
        logic [31:0]        thr;
        logic signed [31:0] shifted;
        mask          = (32'd1 << e) - 32'd1;
        rem           = h & mask;
        thr           = (mask >> 1) + {31'd0, h[31]};
        shifted       = $signed(h) >>> e;
        round_div_pot = shifted + {31'd0, (rem > thr)};
    endfunction

    logic signed [31:0] bias_q, mult_q, shift_q, off_q, amin_q, amax_q;
    logic               adv_s;
    logic               s1_v_q, s1_last_q;
    logic [31:0]        s1_x_q, s1_x_d, s1_sum_s;
    logic               s2_v_q, s2_last_q, s2_sat_q, s2_sat_d;
    logic signed [63:0] s2_ab_q, s2_ab_d;
    logic               s3_v_q, s3_last_q;
    logic signed [31:0] s3_r_q, s3_r_d;
    logic signed [63:0] s3_sum_s, s3_adj_s;
    logic [31:0]        s3_h_s;
    logic signed [31:0] s4_v_s, s4_clamp_s;
    logic [7:0]         s4_byte_s;
    logic [1:0]         k_q;
    logic [23:0]        pack_q;
    logic [31:0]        pack_word_s;
    logic               emit_s;
    logic               out_valid_q;
    logic [31:0]        out_data_q;
    logic [2:0]         out_bytes_q;
    logic               unused_bits_s;

    assign adv_s = !out_valid_q || out_ready;

    // Configuration registers; writes are dropped while any data is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q  <= 32'sd0;
            mult_q  <= 32'sh4000_0000;
            shift_q <= 32'sd0;
            off_q   <= 32'sd0;
            amin_q  <= -32'sd128;
            amax_q  <= 32'sd127;
        end else if (cfg_we && !busy) begin
            case (cfg_addr)
                3'd0:    bias_q  <= cfg_data;
                3'd1:    mult_q  <= cfg_data;
                3'd2:    shift_q <= cfg_data;
                3'd3:    off_q   <= cfg_data;
                3'd4:    amin_q  <= cfg_data;
                3'd5:    amax_q  <= cfg_data;
                default: ;
            endcase
        end
    end

    // S1 bias add with optional left shift, and S2 product / saturation detect.
    always_comb begin
        s1_sum_s = in_acc + bias_q;
        if (shift_q > 32'sd0) begin
            s1_x_d = s1_sum_s << shift_q[4:0];
        end else begin
            s1_x_d = s1_sum_s;
        end
        s2_sat_d = (s1_x_q == 32'h8000_0000) && (mult_q == 32'sh8000_0000);
        s2_ab_d  = $signed({{32{s1_x_q[31]}}, s1_x_q}) * $signed({{32{mult_q[31]}}, mult_q});
    end

    // S3 high-half extraction with nudge, truncation toward zero, then rounding right shift.
    always_comb begin
        s3_sum_s = s2_ab_q + (s2_ab_q[63] ? 64'shFFFF_FFFF_C000_0001 : 64'sh0000_0000_4000_0000);
        if (s3_sum_s[63]) begin
            s3_adj_s = s3_sum_s + 64'sh0000_0000_7FFF_FFFF;
        end else begin
            s3_adj_s = s3_sum_s;
        end
        if (s2_sat_q) begin
            s3_h_s = 32'h7FFF_FFFF;
        end else begin
            s3_h_s = s3_adj_s[62:31];
        end
        if (shift_q < 32'sd0) begin
            s3_r_d = round_div_pot(s3_h_s, 5'd0 - shift_q[4:0]);
        end else begin
            s3_r_d = s3_h_s;
        end
    end

    // S4 offset, clamp and placement of the byte into the next free slot.
    always_comb begin
        s4_v_s = s3_r_q + off_q;
        if (s4_v_s < amin_q) begin
            s4_clamp_s = amin_q;
        end else if (s4_v_s > amax_q) begin
            s4_clamp_s = amax_q;
        end else begin
            s4_clamp_s = s4_v_s;
        end
        s4_byte_s = s4_clamp_s[7:0];
        case (k_q)
            2'd0:    pack_word_s = {s4_byte_s, 24'd0};
            2'd1:    pack_word_s = {pack_q[23:16], s4_byte_s, 16'd0};
            2'd2:    pack_word_s = {pack_q[23:8], s4_byte_s, 8'd0};
            2'd3:    pack_word_s = {pack_q, s4_byte_s};
            default: pack_word_s = {s4_byte_s, 24'd0};
        endcase
        emit_s = s3_v_q && ((k_q == 2'd3) || s3_last_q);
    end

    assign unused_bits_s = ^{s3_adj_s[63], s3_adj_s[30:0], s4_clamp_s[31:8]};

    // Pipeline stages, packer and output register; everything freezes while a word is refused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_x_q      <= 32'd0;
            s2_v_q      <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_sat_q    <= 1'b0;
            s2_ab_q     <= 64'sd0;
            s3_v_q      <= 1'b0;
            s3_last_q   <= 1'b0;
            s3_r_q      <= 32'sd0;
            k_q         <= 2'd0;
            pack_q      <= 24'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_bytes_q <= 3'd0;
        end else if (adv_s) begin
            s1_v_q      <= in_valid;
            s1_last_q   <= in_last;
            s1_x_q      <= s1_x_d;
            s2_v_q      <= s1_v_q;
            s2_last_q   <= s1_last_q;
            s2_sat_q    <= s2_sat_d;
            s2_ab_q     <= s2_ab_d;
            s3_v_q      <= s2_v_q;
            s3_last_q   <= s2_last_q;
            s3_r_q      <= s3_r_d;
            out_valid_q <= emit_s;
            if (s3_v_q) begin
                if (emit_s) begin
                    out_data_q  <= pack_word_s;
                    out_bytes_q <= {1'b0, k_q} + 3'd1;
                    k_q         <= 2'd0;
                    pack_q      <= 24'd0;
                end else begin
                    pack_q <= pack_word_s[31:8];
                    k_q    <= k_q + 2'd1;
                end
            end
        end
    end

    assign in_ready  = adv_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_bytes = out_bytes_q;
    assign busy      = s1_v_q || s2_v_q || s3_v_q || (k_q != 2'd0) || out_valid_q;

endmodule

// File: tb/tb_requant_pack.sv
// Bench for requant_pack: directed table, latency/stall/reset sequences, and a
// randomized run scored against an arithmetic reference model.
module tb_requant_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_acc;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        busy;

    requant_pack dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bytes(out_bytes), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  nbytes;
    } word_t;

    typedef struct {
        logic [31:0] bias;
        logic [31:0] mult;
        logic [31:0] shift;
        logic [31:0] off;
        logic [31:0] amin;
        logic [31:0] amax;
        logic [31:0] acc;
        logic [31:0] exp_word;
    } vec_t;

    int     checks = 0;
    int     failures = 0;
    int     ready_mode = 0;
    bit     use_model = 1'b0;
    word_t  exp_q[$];
    logic [7:0] m_bytes[$];
    int     m_bias, m_mult, m_shift, m_off, m_amin, m_amax;
    vec_t   tbl[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic model_defaults();
        m_bias = 0; m_mult = 32'h4000_0000; m_shift = 0; m_off = 0; m_amin = -128; m_amax = 127;
    endtask

    function automatic logic [7:0] model_byte(input int acc);
        int     x, v, min_int;
        longint ab, h, r, p, nudge;
        min_int = 32'h8000_0000;
        x = acc + m_bias;
        if (m_shift > 0) x = x <<< m_shift;
        if (x == min_int && m_mult == min_int) begin
            h = 64'sd2147483647;
        end else begin
            ab = longint'(x) * longint'(m_mult);
            if (ab >= 0) nudge = 64'sd1 << 30;
            else nudge = 64'sd1 - (64'sd1 << 30);
            h = (ab + nudge) / (64'sd1 << 31);
        end
        if (m_shift < 0) begin
            p = 64'sd1 << (-m_shift);
            if (h >= 0) r = (h + p / 2) / p;
            else r = -((-h + p / 2) / p);
        end else begin
            r = h;
        end
        v = int'(r) + m_off;
        if (v < m_amin) v = m_amin;
        else if (v > m_amax) v = m_amax;
        return v[7:0];
    endfunction

    task automatic model_accept(input logic [31:0] acc, input logic last);
        word_t w;
        m_bytes.push_back(model_byte(int'(acc)));
        if (m_bytes.size() == 4 || last) begin
            w.data = 32'd0;
            w.nbytes = 3'(m_bytes.size());
            for (int i = 0; i < m_bytes.size(); i++) w.data[31 - 8 * i -: 8] = m_bytes[i];
            exp_q.push_back(w);
            m_bytes.delete();
        end
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [2:0] n);
        word_t w;
        w.data = d;
        w.nbytes = n;
        exp_q.push_back(w);
    endtask

    // Ends one time unit after a rising edge, like every other driver task.
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: busy=%0b pending=%0d expected idle", busy, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        wait_idle();
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        case (a)
            3'd0: m_bias = d;
            3'd1: m_mult = d;
            3'd2: m_shift = d;
            3'd3: m_off = d;
            3'd4: m_amin = d;
            3'd5: m_amax = d;
            default: ;
        endcase
    endtask

    task automatic set_cfg(input logic [31:0] b, input logic [31:0] m, input logic [31:0] s,
                           input logic [31:0] o, input logic [31:0] lo, input logic [31:0] hi);
        cfg_write(3'd0, b); cfg_write(3'd1, m); cfg_write(3'd2, s);
        cfg_write(3'd3, o); cfg_write(3'd4, lo); cfg_write(3'd5, hi);
    endtask

    task automatic send(input logic [31:0] acc, input logic last);
        int n;
        in_valid = 1'b1; in_acc = acc; in_last = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready=%0b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        if (use_model) model_accept(acc, last);
    endtask

    // Consumer-side ready pattern, changed just after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) out_ready = 1'b1;
            else if (ready_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
            else out_ready = 1'b0;
        end
    end

    // Scoreboard: compares each accepted word and checks stability while refused.
    initial begin : monitor
        logic [31:0] held_d;
        logic [2:0]  held_b;
        logic        held_v;
        word_t       w;
        held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v = 1'b0;
            end else if (out_valid) begin
                if (held_v) begin
                    check("stall_data", out_data, held_d);
                    check("stall_bytes", {29'd0, out_bytes}, {29'd0, held_b});
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word: got=%h expected none", out_data);
                    end else begin
                        w = exp_q.pop_front();
                        check("word_data", out_data, w.data);
                        check("word_bytes", {29'd0, out_bytes}, {29'd0, w.nbytes});
                    end
                    held_v = 1'b0;
                end else begin
                    held_v = 1'b1;
                    held_d = out_data;
                    held_b = out_bytes;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        tbl[0] = '{32'd0,  32'h4000_0000, 32'd0,         32'd0,         32'hFFFF_FF80, 32'd127, 32'd100,       32'h3200_0000};
        tbl[1] = '{32'd0,  32'h4000_0000, 32'hFFFF_FFFE, 32'd0,         32'hFFFF_FF80, 32'd127, 32'hFFFF_FFF4, 32'hFE00_0000};
        tbl[2] = '{32'd0,  32'h8000_0000, 32'd0,         32'd0,         32'hFFFF_FF80, 32'd127, 32'h8000_0000, 32'h7F00_0000};
        tbl[3] = '{32'd20, 32'h4000_0000, 32'd0,         32'hFFFF_FF80, 32'd0,         32'd127, 32'd100,       32'h0000_0000};
        tbl[4] = '{32'd20, 32'h4000_0000, 32'd0,         32'd0,         32'hFFFF_FF80, 32'd10,  32'd100,       32'h0A00_0000};
        tbl[5] = '{32'd0,  32'h4000_0000, 32'd2,         32'd0,         32'hFFFF_FF80, 32'd127, 32'd3,         32'h0600_0000};
        tbl[6] = '{32'd0,  32'h8000_0000, 32'd0,         32'd0,         32'hFFFF_FF80, 32'd127, 32'd5,         32'hFB00_0000};
        tbl[7] = '{32'd0,  32'h7FFF_FFFF, 32'd0,         32'd0,         32'hFFFF_FF80, 32'd127, 32'hFFFF_FC18, 32'h8000_0000};

        model_defaults();
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 32'd0;
        in_valid = 1'b0; in_acc = 32'd0; in_last = 1'b0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_bytes", {29'd0, out_bytes}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset configuration: 100 * 0.5 -> 50
        expect_word(32'h3200_0000, 3'd1);
        send(32'd100, 1'b1);
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            set_cfg(tbl[i].bias, tbl[i].mult, tbl[i].shift, tbl[i].off, tbl[i].amin, tbl[i].amax);
            expect_word(tbl[i].exp_word, 3'd1);
            send(tbl[i].acc, 1'b1);
            wait_idle();
        end

        // Full word and latency from last accept to out_valid
        set_cfg(32'd20, 32'h4000_0000, 32'd0, 32'hFFFF_FF80, 32'hFFFF_FF80, 32'd127);
        expect_word(32'hBCBC_BCBC, 3'd4);
        send(32'd100, 1'b0);
        send(32'd100, 1'b0);
        send(32'd100, 1'b0);
        send(32'd100, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("latency_edge%0d", c), {31'd0, out_valid}, (c == 3) ? 32'd1 : 32'd0);
        end
        wait_idle();

        // Back-to-back last-tagged elements each form their own word
        expect_word(32'hBC00_0000, 3'd1);
        expect_word(32'hBC00_0000, 3'd1);
        send(32'd100, 1'b1);
        send(32'd100, 1'b1);
        wait_idle();

        // Backpressure with 12 elements
        set_cfg(32'd0, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FF80, 32'd127);
        expect_word(32'h0102_0304, 3'd4);
        expect_word(32'h0506_0708, 3'd4);
        expect_word(32'h090A_0B0C, 3'd4);
        ready_mode = 1;
        for (int i = 1; i <= 12; i++) send(32'(i), (i == 12));
        wait_idle();
        ready_mode = 0;

        // Config write while busy is dropped
        set_cfg(32'd0, 32'h4000_0000, 32'd0, 32'd0, 32'hFFFF_FF80, 32'd127);
        expect_word(32'h3232_0000, 3'd2);
        send(32'd100, 1'b0);
        check("busy_during_write", {31'd0, busy}, 32'd1);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 32'd1000;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        send(32'd100, 1'b1);
        wait_idle();

        // Randomized streams against the reference model
        use_model = 1'b1;
        ready_mode = 1;
        for (int round = 0; round < 5; round++) begin
            int lo, hi;
            lo = int'($urandom_range(0, 255)) - 128;
            hi = lo + int'($urandom_range(0, 32'(127 - lo)));
            set_cfg($urandom_range(0, 4000) - 2000, $urandom(), 32'(int'($urandom_range(0, 38)) - 31),
                    32'(int'($urandom_range(0, 400)) - 200), 32'(lo), 32'(hi));
            for (int i = 0; i < 40; i++) begin
                send($urandom(), (i == 39) || ($urandom_range(0, 4) == 0));
            end
            wait_idle();
        end
        ready_mode = 0;

        // Asynchronous reset with a refused word pending
        set_cfg(32'd20, 32'h4000_0000, 32'd0, 32'hFFFF_FF80, 32'hFFFF_FF80, 32'd127);
        ready_mode = 2;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(32'd100, 1'b0);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_data", out_data, 32'd0);
        exp_q.delete();
        m_bytes.delete();
        model_defaults();
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        use_model = 1'b0;
        expect_word(32'h3200_0000, 3'd1);
        send(32'd100, 1'b1);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/requant_pack.md
# requant_pack

Post-accumulation requantization stage that sits directly downstream of the matrix-multiply buffer read path in the CFU. It consumes signed 32-bit accumulator values one per handshake and applies bias add, TFLite-exact MultiplyByQuantizedMultiplier, output offset and activation clamp. It packs the resulting int8 values four per 32-bit word for return to the CPU. The block is a 4-stage, fully stallable pipeline with valid/ready on both sides.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  config write strobe
- cfg_addr  in  3  0 bias, 1 multiplier, 2 shift, 3 output_offset, 4 act_min, 5 act_max; 6–7 ignored
- cfg_data  in  32  config value (signed)
- in_valid  in  1  accumulator valid
- in_ready  out  1  block accepts accumulator this cycle
- in_acc  in  32  signed accumulator
- in_last  in  1  final element of stream; flushes partial word
- out_valid  out  1  packed word valid
- out_ready  in  1  consumer accepts word
- out_data  out  32  packed int8 results; first element in [31:24]
- out_bytes  out  3  number of valid bytes in out_data, 1..4
- busy  out  1  any stage or packer holds data

## Operation
- Config registers reset to: bias 0, multiplier 0x40000000, shift 0, output_offset 0, act_min -128, act_max 127. A cfg_we is ignored when busy=1. Legal shift range is -31..+7; behaviour outside that range is unspecified.
- Accept when in_valid && in_ready.
- S1:
  - x = in_acc + bias, 32-bit wrap.
  - If shift>0: x = x << shift, 32-bit wrap.
- S2:
  - If x == 0x80000000 && multiplier == 0x80000000, flag saturate.
  - Otherwise ab = x * multiplier, 64-bit signed, registered.
- S3:
  - If saturate, h = 0x7FFFFFFF.
  - Otherwise nudge = 2^30 if ab>=0, else 1-2^30. h = (ab+nudge)/2^31, truncated toward zero.
  - If shift<0, with e=-shift: mask = 2^e-1, rem = h & mask, thr = (mask>>1) + (h<0). r = (h >>> e) + (rem > thr). If shift>=0, r = h.
- S4:
  - v = r + output_offset, 32-bit.
  - Clamp v to [act_min, act_max].
  - Byte = v[7:0], written into the pack register at slot 3-k (k = bytes already packed).
- Word emission:
  - The pack register is emitted when k reaches 4, or when a byte tagged in_last is packed.
  - Unused slots are 0. out_bytes = k.
  - k resets to 0 after emission.
- Advance enable adv = !out_valid || out_ready.
  - All stages, valid bits and the last tag move only when adv=1.
  - in_ready = adv.
- busy = any stage valid || k!=0 || out_valid.

## Timing
- Reset (async assert): out_valid 0, out_data 0, out_bytes 0, busy 0, in_ready 1, all stage valids 0, k 0.
- Element accepted at edge n is packed at edge n+3.
- A word completed at edge n+3 drives out_valid=1 from that edge.
- Full throughput: one element per cycle, one word per 4 cycles, no bubbles while out_ready=1.
- out_valid && out_ready together with a new byte packing on the same edge: the old word retires and the new byte starts a fresh word at slot [31:24]. No element is lost or duplicated.
- out_valid=1 && out_ready=0: entire pipe freezes, in_ready=0, and out_data/out_bytes are held stable.
- in_last with k=0 after packing yields out_bytes=1. Consecutive last-tagged elements each produce their own word.
- Reset mid-stream discards all in-flight data. Config returns to reset values.

## Test plan
- Config bias=20, mult=0x40000000, shift=0, offset=-128. Feed acc=100 three times, then acc=100 with in_last. Expect one word 0xBCBCBCBC, out_bytes=4, out_valid 3 cycles after the 4th accept.
- Rounding, offset 0, mult=0x40000000, shift=-2. Feed acc=-12 with last. Expect h=-6, r=-2, out_data 0xFE000000, out_bytes=1.
- Saturation: bias 0, mult=0x80000000, shift 0, acc=0x80000000 with last. Expect 0x7F000000.
- Clamp: act_min=0, bias 20, mult 0x40000000, offset -128, acc=100. Expect byte 0x00. Then act_max=10 with offset 0 gives byte 0x0A.
- Backpressure: stream 12 elements 1..12 with mult=0x7FFFFFFF, shift 0, last on the 12th. Randomize out_ready. Expect words 0x01020304, 0x05060708, 0x090A0B0C in order, out_data stable while stalled, no loss.
- cfg_we while busy: the write is ignored and results use the old value. Async reset mid-stream: out_valid drops immediately and the next stream is clean.
